// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- multiplexed seven-segment display controller on the S86 I/O bus.
//
// Holds digit nibbles, digit-enable / decimal-point masks and a display-on
// bit in a small register file behind an I/O chip select. It scans up to
// eight common-anode digits, hex-decodes the active digit and drives
// registered, active-low anode and segment outputs.
//
// Optional feature: define SEG_BLINK_EN to add a free-running blink counter
// and the BLINK register (a=7). Without it a=7 reads 0x00 and writes are
// ignored.
//
// Parameters:
//   DIGITS    number of scanned digits (2..8)
//   DIV       clock cycles per digit slot (>=2)
//   BLINK_BIT counter bit used as blink phase (SEG_BLINK_EN only)
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   CS_N   in   chip select, active-low
//   IOW_N  in   I/O write strobe, active-low
//   IOR_N  in   I/O read strobe, active-low
//   a      in   register address [2:0]
//   din    in   write data [7:0]
//   dout   out  read data [7:0], combinational, 0x00 when not read
//   an     out  digit anodes [DIGITS-1:0], active-low, registered
//   segs   out  segments {dp,g..a}, active-low, registered

module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int DIV       = 10000,
  parameter int BLINK_BIT = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS_N,
  input  logic              IOW_N,
  input  logic              IOR_N,
  input  logic [2:0]        a,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        segs
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  // Active-low hex decode, segment order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic             iow_n_q;          // IOW_N seen at the previous edge
  logic [3:0][7:0]  data_q, data_d;   // data_q[k] = {digit 2k+1, digit 2k}
  logic [7:0]       en_q, en_d;
  logic [7:0]       dp_q, dp_d;
  logic             on_q, on_d;
  logic             wr_en;
  logic [7:0]       rd_blink;         // BLINK read value
  logic             blink_sup;        // current digit blanked by blink phase

  // One write per strobe: only the first cycle with IOW_N low counts.
  // iow_n_q resets high, so a strobe already low after reset is new.
  assign wr_en = ~CS_N & ~IOW_N & iow_n_q;

  always_comb begin
    data_d = data_q;
    en_d   = en_q;
    dp_d   = dp_q;
    on_d   = on_q;
    if (wr_en) begin
      case (a)
        3'd0, 3'd1, 3'd2, 3'd3: data_d[a[1:0]] = din;
        3'd4:                   en_d = din;
        3'd5:                   dp_d = din;
        3'd6:                   on_d = din[0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner: prescaler and digit index
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          advance;
  logic [2:0]    sel;                 // idx widened to address 8-bit masks
  logic [31:0]   nib_vec;
  logic [3:0]    nib;

  assign advance = (pre_q == PRE_MAX);
  assign sel     = 3'(idx_q);
  assign nib_vec = data_q;
  assign nib     = nib_vec[{sel, 2'b00} +: 4];

  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (advance) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink
  // ---------------------------------------------------------------------------
`ifdef SEG_BLINK_EN
  logic [BLINK_BIT:0] bcnt_q, bcnt_d;
  logic [7:0]         blink_q, blink_d;

  always_comb begin
    bcnt_d  = bcnt_q + (BLINK_BIT+1)'(1);
    blink_d = blink_q;
    if (wr_en && a == 3'd7) blink_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      blink_q <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_sup = blink_q[sel] & bcnt_q[BLINK_BIT];
  assign rd_blink  = blink_q;
`else
  assign blink_sup = 1'b0;
  assign rd_blink  = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        segs_q, segs_d;
  logic              lit;

  assign lit = on_q & en_q[sel] & ~blink_sup;

  // The edge that moves idx loads blank, so the old digit's segments never
  // appear under the new anode (anti-ghosting).
  always_comb begin
    an_d   = '1;
    segs_d = 8'hFF;
    if (!advance && lit) begin
      an_d   = ~(DIGITS'(1) << idx_q);
      segs_d = {~dp_q[sel], hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iow_n_q <= 1'b1;
      data_q  <= '0;
      en_q    <= '0;
      dp_q    <= '0;
      on_q    <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      segs_q  <= 8'hFF;
    end else begin
      iow_n_q <= IOW_N;
      data_q  <= data_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      on_q    <= on_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      segs_q  <= segs_d;
    end
  end

  assign an   = an_q;
  assign segs = segs_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    dout = 8'h00;
    if (!CS_N && !IOR_N) begin
      case (a)
        3'd0, 3'd1, 3'd2, 3'd3: dout = data_q[a[1:0]];
        3'd4:                   dout = en_q;
        3'd5:                   dout = dp_q;
        3'd6:                   dout = {7'b0, on_q};
        default:                dout = rd_blink;
      endcase
    end
  end

endmodule
